// File: rtl/aes_encrypt_iter.sv
// -----------------------------------------------------------------------------
// aes_encrypt_iter
//
// Iterative AES-128 encryptor. One cipher round is computed per clock. The
// round key is expanded on the fly from the previous round key in the same
// cycle. This keeps the datapath to a single round's worth of logic.
//
// Ports
//   clk         input   1    clock, all state updates on the rising edge
//   rst         input   1    synchronous active-high reset, beats E_int
//   E_int       input   1    start request (level), honoured in IDLE/DONE
//   plaintext   input 128    block to encrypt, byte 0 = bits [127:120]
//   key         input 128    AES-128 cipher key, byte 0 = bits [127:120]
//   ciphertext  output 128   encrypted block, registered
//   E_done      output  1    result valid, registered
//
// Timing
//   The start edge N loads plaintext^key and key.
//   Edges N+1..N+9 run rounds 1..9.
//   Edge N+10 (FINAL, counter 10) computes round 10 into the state register.
//   Edge N+11 (FINAL, counter 11) moves the result to ciphertext and raises
//   E_done.
//   Total latency is therefore 11 edges. ciphertext only ever changes on a
//   FINAL edge or on reset.
// -----------------------------------------------------------------------------
module aes_encrypt_iter (
   input  logic         clk,
   input  logic         rst,
   input  logic         E_int,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic [127:0] ciphertext,
   output logic         E_done
);

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_e;

   // Forward S-box, row-major. Entry 0x00 sits in the top byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [10:0] base;
      // Entry b lives at bit offset (255-b)*8; ~b equals 255-b for 8 bits.
      base = {~b, 3'b000};
      return SBOX_TABLE[base +: 8];
   endfunction

   // Multiply by x in GF(2^8), reduced by 0x11B.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      logic [7:0] rc;
      case (rnd)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   fsm_e         fsm_q;
   logic [127:0] state_q;
   logic [127:0] rk_q;        // round key of the previous round
   logic [3:0]   cnt_q;       // round counter
   logic [127:0] ct_q;
   logic         done_q;

   // ---------------- key schedule: rk_q (round r-1) -> rk_d (round r) -----
   logic [31:0]  kw0, kw1, kw2, kw3, rot_w, sub_w, temp_w;
   logic [31:0]  nw0, nw1, nw2, nw3;
   logic [127:0] rk_d;

   assign kw0   = rk_q[127:96];
   assign kw1   = rk_q[95:64];
   assign kw2   = rk_q[63:32];
   assign kw3   = rk_q[31:0];
   assign rot_w = {kw3[23:0], kw3[31:24]};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_key_sub
         assign sub_w[31-8*gi -: 8] = sbox(rot_w[31-8*gi -: 8]);
      end
   endgenerate

   assign temp_w = sub_w ^ {rcon(cnt_q), 24'h000000};
   assign nw0    = kw0 ^ temp_w;
   assign nw1    = kw1 ^ nw0;
   assign nw2    = kw2 ^ nw1;
   assign nw3    = kw3 ^ nw2;
   assign rk_d   = {nw0, nw1, nw2, nw3};

   // ---------------- round datapath ---------------------------------------
   logic [7:0]   sb_byte [16];
   logic [7:0]   sr_byte [16];
   logic [7:0]   mc_byte [16];
   logic [127:0] sr_vec, mc_vec;
   logic [127:0] round_mix, round_last;

   generate
      for (gi = 0; gi < 16; gi++) begin : g_sub_shift
         assign sb_byte[gi] = sbox(state_q[127-8*gi -: 8]);
         // Byte gi is at row gi%4, column gi/4. Row r rotates left by r
         // columns, so the byte comes from column (c+r)%4 of the same row.
         assign sr_byte[gi] = sb_byte[4*(((gi/4) + (gi%4)) % 4) + (gi%4)];
         assign sr_vec[127-8*gi -: 8] = sr_byte[gi];
         assign mc_vec[127-8*gi -: 8] = mc_byte[gi];
      end

      for (gi = 0; gi < 4; gi++) begin : g_mix
         logic [7:0] a0, a1, a2, a3;
         assign a0 = sr_byte[4*gi+0];
         assign a1 = sr_byte[4*gi+1];
         assign a2 = sr_byte[4*gi+2];
         assign a3 = sr_byte[4*gi+3];
         // Rows of the fixed matrix [2 3 1 1] rotated; 3*a = xtime(a)^a.
         assign mc_byte[4*gi+0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         assign mc_byte[4*gi+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         assign mc_byte[4*gi+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         assign mc_byte[4*gi+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
   endgenerate

   assign round_mix  = mc_vec ^ rk_d;
   assign round_last = sr_vec ^ rk_d;

   // ---------------- control ----------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         rk_q    <= '0;
         cnt_q   <= '0;
         ct_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         case (fsm_q)
            IDLE, DONE: begin
               if (E_int) begin
                  state_q <= plaintext ^ key;
                  rk_q    <= key;
                  cnt_q   <= 4'd1;
                  done_q  <= 1'b0;
                  fsm_q   <= ROUND;
               end
            end
            ROUND: begin
               state_q <= round_mix;
               rk_q    <= rk_d;
               cnt_q   <= cnt_q + 4'd1;
               if (cnt_q == 4'd9) begin
                  fsm_q <= FINAL;
               end
            end
            FINAL: begin
               // Counter 10 computes the last round. Counter 11 publishes it.
               if (cnt_q == 4'd10) begin
                  state_q <= round_last;
                  rk_q    <= rk_d;
                  cnt_q   <= 4'd11;
               end else begin
                  ct_q   <= state_q;
                  done_q <= 1'b1;
                  fsm_q  <= DONE;
               end
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

   assign ciphertext = ct_q;
   assign E_done     = done_q;

endmodule
